// File: rtl/nmr_bstrm_pkg.sv
// Shared constants and types for the pulse-sequencer command SRAM loader.
// Command word layout, CTRL flag bits and the loader FSM state encoding.
package nmr_bstrm_pkg;

  localparam int BEATS_PER_WORD = 4;

  localparam int CTRL_OFS = 0;
  localparam int CTRL_W   = 16;
  localparam int LOOP_OFS = 16;
  localparam int LOOP_W   = 16;
  localparam int IDLY_OFS = 32;
  localparam int IDLY_W   = 32;
  localparam int PLS_OFS  = 64;
  localparam int PLS_W    = 32;
  localparam int EDLY_OFS = 96;
  localparam int EDLY_W   = 32;

  localparam int CTRL_LOOP_END   = 0;
  localparam int CTRL_LOOP_START = 1;
  localparam int CTRL_SEQ_END    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_FINISH,
    ST_DRAIN
  } ld_state_e;

endpackage

// File: rtl/nmr_bstrm_seq_loader_beat_pack.sv
// Beat-to-word packer: lane register, beat index and byte enables.
// full flags the accept that closes a word (lane 3 or last beat).
module nmr_bstrm_beat_pack
  import nmr_bstrm_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int DAT_WIDTH = 128,
  parameter int BE_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic                 clear,
  input  logic                 last,
  input  logic [IN_WIDTH-1:0]  dat,
  output logic [DAT_WIDTH-1:0] word,
  output logic [BE_WIDTH-1:0]  byteen,
  output logic                 full
);

  localparam int IW  = $clog2(BEATS_PER_WORD);
  localparam int BPL = IN_WIDTH / 8;

  logic [BEATS_PER_WORD-1:0][IN_WIDTH-1:0] lane_q;
  logic [IW-1:0]                           idx_q;
  logic [IW:0]                             cnt_q;

  // Store each accepted beat into its lane; clear empties the word.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      lane_q[idx_q] <= dat;
      idx_q         <= idx_q + 1'b1;
      cnt_q         <= cnt_q + 1'b1;
    end
  end

  // Four byte enables per received lane, lowest lanes first.
  always_comb begin
    byteen = '0;
    for (int i = 0; i < BE_WIDTH; i++) begin
      byteen[i] = (i / BPL) < int'(cnt_q);
    end
  end

  assign word = lane_q;
  assign full = accept &&
    ((idx_q == IW'(BEATS_PER_WORD - 1)) || last);

endmodule

// File: rtl/nmr_bstrm_seq_loader.sv
// Command SRAM writer: packs 32-bit beats into 128-bit words.
// Optional running XOR checksum output: NMR_BSTRM_LDR_CKSUM_EN.
module nmr_bstrm_seq_loader
  import nmr_bstrm_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH   = 8,
  parameter int SRAM_DAT_WIDTH    = 128,
  parameter int SRAM_BYTEEN_WIDTH = 16,
  parameter int IN_WIDTH          = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         LD_START,
  input  logic [SRAM_ADDR_WIDTH-1:0]   LD_BASE,
  input  logic [IN_WIDTH-1:0]          IN_DAT,
  input  logic                         IN_VALID,
  input  logic                         IN_LAST,
  output logic                         IN_READY,
  input  logic                         PLAYER_BUSY,
  output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
  output logic                         SRAM_CS,
  output logic                         SRAM_CLKEN,
  output logic                         SRAM_WR,
  output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
  output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN,
  output logic [SRAM_ADDR_WIDTH:0]     WORDS,
  output logic                         DONE,
  output logic                         ERR
`ifdef NMR_BSTRM_LDR_CKSUM_EN
  ,
  output logic [IN_WIDTH-1:0]          CKSUM
`endif
);

  ld_state_e state_q, state_d;

  logic [SRAM_ADDR_WIDTH-1:0]   addr_q;
  logic [SRAM_ADDR_WIDTH:0]     words_q;
  logic                         err_q;
  logic                         ovf_q;
  logic                         last_q;
  logic                         beat_acc;
  logic                         pack_acc;
  logic                         start_ok;
  logic                         word_close;
  logic [SRAM_DAT_WIDTH-1:0]    pack_word;
  logic [SRAM_BYTEEN_WIDTH-1:0] pack_be;

  assign beat_acc = IN_VALID && IN_READY;
  assign pack_acc = beat_acc && (state_q == ST_ACCEPT) && !ovf_q;
  assign start_ok = (state_q == ST_IDLE) && LD_START && !PLAYER_BUSY;

  nmr_bstrm_beat_pack #(
    .IN_WIDTH  (IN_WIDTH),
    .DAT_WIDTH (SRAM_DAT_WIDTH),
    .BE_WIDTH  (SRAM_BYTEEN_WIDTH)
  ) u_pack (
    .clk    (CLK),
    .rst    (RST),
    .accept (pack_acc),
    .clear  (start_ok || (state_q == ST_WRITE)),
    .last   (IN_LAST),
    .dat    (IN_DAT),
    .word   (pack_word),
    .byteen (pack_be),
    .full   (word_close)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: a beat after the top-address write diverts to DRAIN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_ACCEPT;
      ST_ACCEPT: begin
        if (beat_acc && ovf_q)
          state_d = IN_LAST ? ST_FINISH : ST_DRAIN;
        else if (word_close)
          state_d = ST_WRITE;
      end
      ST_WRITE:  state_d = last_q ? ST_FINISH : ST_ACCEPT;
      ST_FINISH: state_d = ST_IDLE;
      ST_DRAIN:  if (beat_acc && IN_LAST) state_d = ST_FINISH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs: SRAM port is only active for the single WRITE cycle.
  always_comb begin
    IN_READY    = 1'b0;
    SRAM_CS     = 1'b0;
    SRAM_CLKEN  = 1'b0;
    SRAM_WR     = 1'b0;
    SRAM_ADDR   = '0;
    SRAM_WR_DAT = '0;
    SRAM_BYTEEN = '0;
    DONE        = 1'b0;
    unique case (state_q)
      ST_ACCEPT: IN_READY = !PLAYER_BUSY;
      ST_WRITE: begin
        SRAM_CS     = 1'b1;
        SRAM_CLKEN  = 1'b1;
        SRAM_WR     = 1'b1;
        SRAM_ADDR   = addr_q;
        SRAM_WR_DAT = pack_word;
        SRAM_BYTEEN = pack_be;
      end
      ST_FINISH: DONE = 1'b1;
      ST_DRAIN:  IN_READY = 1'b1;
      default: ;
    endcase
  end

  // Load bookkeeping: address saturates at the top instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q  <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q  <= LD_BASE;
        words_q <= '0;
        err_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end
      if (pack_acc) last_q <= IN_LAST;
      if (state_q == ST_WRITE) begin
        words_q <= words_q + 1'b1;
        if (addr_q == '1) ovf_q  <= 1'b1;
        else              addr_q <= addr_q + 1'b1;
      end
      if ((state_q == ST_ACCEPT) && beat_acc && ovf_q)
        err_q <= 1'b1;
    end
  end

  assign WORDS = words_q;
  assign ERR   = err_q;

`ifdef NMR_BSTRM_LDR_CKSUM_EN
  logic [IN_WIDTH-1:0] cksum_q;

  // Running XOR of every accepted beat, drained ones included.
  always_ff @(posedge CLK) begin
    if (RST || start_ok) cksum_q <= '0;
    else if (beat_acc)   cksum_q <= cksum_q ^ IN_DAT;
  end

  assign CKSUM = cksum_q;
`endif

endmodule

// File: tb/tb_nmr_bstrm_seq_loader.sv
// Directed bench for the command SRAM loader.
// Writes are captured by a negedge monitor and compared to hand values.
module tb_nmr_bstrm_seq_loader;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         LD_START = 1'b0;
  logic [7:0]   LD_BASE = '0;
  logic [31:0]  IN_DAT = '0;
  logic         IN_VALID = 1'b0;
  logic         IN_LAST = 1'b0;
  logic         IN_READY;
  logic         PLAYER_BUSY = 1'b0;
  logic [7:0]   SRAM_ADDR;
  logic         SRAM_CS;
  logic         SRAM_CLKEN;
  logic         SRAM_WR;
  logic [127:0] SRAM_WR_DAT;
  logic [15:0]  SRAM_BYTEEN;
  logic [8:0]   WORDS;
  logic         DONE;
  logic         ERR;
`ifdef NMR_BSTRM_LDR_CKSUM_EN
  logic [31:0]  CKSUM;
`endif

  nmr_bstrm_seq_loader dut (
    .CLK         (CLK),
    .RST         (RST),
    .LD_START    (LD_START),
    .LD_BASE     (LD_BASE),
    .IN_DAT      (IN_DAT),
    .IN_VALID    (IN_VALID),
    .IN_LAST     (IN_LAST),
    .IN_READY    (IN_READY),
    .PLAYER_BUSY (PLAYER_BUSY),
    .SRAM_ADDR   (SRAM_ADDR),
    .SRAM_CS     (SRAM_CS),
    .SRAM_CLKEN  (SRAM_CLKEN),
    .SRAM_WR     (SRAM_WR),
    .SRAM_WR_DAT (SRAM_WR_DAT),
    .SRAM_BYTEEN (SRAM_BYTEEN),
    .WORDS       (WORDS),
    .DONE        (DONE),
    .ERR         (ERR)
`ifdef NMR_BSTRM_LDR_CKSUM_EN
    ,
    .CKSUM       (CKSUM)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]   a;
    logic [127:0] d;
    logic [15:0]  be;
  } wr_t;

  wr_t wq[$];
  int  checks = 0;
  int  failures = 0;
  int  stalls = 0;
  int  busy_viol = 0;

  always @(negedge CLK) begin
    if (SRAM_WR === 1'b1)
      wq.push_back('{a: SRAM_ADDR, d: SRAM_WR_DAT, be: SRAM_BYTEEN});
    if (IN_VALID && !IN_READY) stalls++;
    if (PLAYER_BUSY && (SRAM_CS || IN_READY)) busy_viol++;
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] b);
    LD_START = 1'b1;
    LD_BASE  = b;
    @(posedge CLK); #1;
    LD_START = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    IN_VALID = 1'b1;
    IN_DAT   = d;
    IN_LAST  = l;
    do begin
      @(negedge CLK);
      n++;
    end while (IN_READY !== 1'b1 && n < 100);
    if (n >= 100) chk("send_timeout", 1'b0, 1'b1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (DONE !== 1'b1 && n < 50);
    chk(tag, 128'(n < 50), 128'd1);
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_ready", IN_READY, 0);
    chk("rst_strobes", {SRAM_CS, SRAM_CLKEN, SRAM_WR, DONE, ERR}, 0);
    chk("rst_addr", SRAM_ADDR, 0);
    chk("rst_dat", SRAM_WR_DAT, 0);
    chk("rst_be", SRAM_BYTEEN, 0);
    chk("rst_words", WORDS, 0);
    @(posedge CLK); #1;

    // single full word
    start(8'h00);
    send(32'h0004_0000, 0);
    send(32'd5, 0);
    send(32'd5, 0);
    send(32'd5, 1);
    chk("w1_latency", SRAM_WR, 1);
    wait_done("w1_done");
    chk("w1_nwr", wq.size(), 1);
    if (wq.size() == 1) begin
      chk("w1_addr", wq[0].a, 8'h00);
      chk("w1_dat", wq[0].d, {32'd5, 32'd5, 32'd5, 32'h0004_0000});
      chk("w1_be", wq[0].be, 16'hFFFF);
    end
    chk("w1_words", WORDS, 1);
    chk("w1_err", ERR, 0);
`ifdef NMR_BSTRM_LDR_CKSUM_EN
    chk("w1_cksum", CKSUM, 32'h0004_0005);
`endif
    wq.delete();

    // three words back to back
    start(8'h00);
    stalls = 0;
    for (int i = 0; i < 12; i++) send(32'(100 + i), i == 11);
    wait_done("w3_done");
    chk("w3_nwr", wq.size(), 3);
    if (wq.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("w3_addr", wq[i].a, 8'(i));
      chk("w3_dat1", wq[1].d, {32'd107, 32'd106, 32'd105, 32'd104});
    end
    chk("w3_stalls", stalls, 2);
    chk("w3_words", WORDS, 3);
    wq.delete();

    // partial word closed by IN_LAST on beat1
    start(8'h10);
    send(32'h0001_0002, 0);
    send(32'd10, 1);
    wait_done("pw_done");
    chk("pw_nwr", wq.size(), 1);
    if (wq.size() == 1) begin
      chk("pw_addr", wq[0].a, 8'h10);
      chk("pw_be", wq[0].be, 16'h00FF);
      chk("pw_dat", wq[0].d, {64'd0, 32'd10, 32'h0001_0002});
    end
    chk("pw_words", WORDS, 1);
    wq.delete();

    // overflow past the top address
    start(8'hFE);
    for (int i = 0; i < 12; i++) send(32'(200 + i), i == 11);
    wait_done("ov_done");
    chk("ov_nwr", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("ov_addr0", wq[0].a, 8'hFE);
      chk("ov_addr1", wq[1].a, 8'hFF);
      chk("ov_dat1", wq[1].d, {32'd207, 32'd206, 32'd205, 32'd204});
    end
    chk("ov_err", ERR, 1);
    chk("ov_words", WORDS, 2);
    wq.delete();

    // player interlock mid-word
    start(8'h20);
    chk("il_err_clr", ERR, 0);
    send(32'hA0, 0);
    send(32'hA1, 0);
    busy_viol = 0;
    PLAYER_BUSY = 1'b1;
    IN_VALID = 1'b1;
    IN_DAT = 32'hA2;
    repeat (5) @(posedge CLK);
    #1;
    chk("il_busy_viol", busy_viol, 0);
    chk("il_no_wr", wq.size(), 0);
    PLAYER_BUSY = 1'b0;
    send(32'hA2, 0);
    send(32'hA3, 1);
    wait_done("il_done");
    chk("il_nwr", wq.size(), 1);
    if (wq.size() == 1) begin
      chk("il_addr", wq[0].a, 8'h20);
      chk("il_dat", wq[0].d, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    end
    wq.delete();

    // LD_START while the player is busy is ignored
    PLAYER_BUSY = 1'b1;
    start(8'h40);
    PLAYER_BUSY = 1'b0;
    @(negedge CLK);
    chk("ib_ready", IN_READY, 0);
    chk("ib_words", WORDS, 1);
    @(posedge CLK); #1;

    // reset in the middle of a word
    start(8'h30);
    send(32'hB0, 0);
    send(32'hB1, 0);
    send(32'hB2, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rm_ready", IN_READY, 0);
    chk("rm_strobes", {SRAM_CS, SRAM_WR, DONE, ERR}, 0);
    chk("rm_words", WORDS, 0);
    chk("rm_be", SRAM_BYTEEN, 0);
    @(posedge CLK); #1;
    chk("rm_no_wr", wq.size(), 0);
    start(8'h50);
    send(32'hC0, 0);
    send(32'hC1, 0);
    send(32'hC2, 0);
    send(32'hC3, 1);
    wait_done("rm_done");
    chk("rm_nwr", wq.size(), 1);
    if (wq.size() == 1) begin
      chk("rm_addr", wq[0].a, 8'h50);
      chk("rm_dat", wq[0].d, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    end
    chk("rm_words2", WORDS, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
